// File: rtl/decode_issue_pkg.sv
// Shared encodings for the decode/issue stage and the DSP48E1-based EXE stages:
// opcodes, instruction field positions, DSP mode constants and the opcode decoder.
package decode_issue_pkg;

    typedef enum logic [4:0] {
        OP_NOP = 5'd0,
        OP_ADD = 5'd1,
        OP_SUB = 5'd2,
        OP_MUL = 5'd3,
        OP_MAC = 5'd4,
        OP_AND = 5'd5,
        OP_OR  = 5'd6,
        OP_XOR = 5'd7
    } opcode_e;

    typedef enum logic {
        ST_ISSUE  = 1'b0,
        ST_BUBBLE = 1'b1
    } state_e;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RD_MSB  = 26;
    localparam int RD_LSB  = 22;
    localparam int RS1_MSB = 21;
    localparam int RS1_LSB = 17;
    localparam int RS2_MSB = 16;
    localparam int RS2_LSB = 12;

    localparam logic [6:0] OPM_NONE  = 7'b0000000;
    localparam logic [6:0] OPM_AB_C  = 7'b0110011;
    localparam logic [6:0] OPM_AB_CO = 7'b0111011;
    localparam logic [6:0] OPM_MUL   = 7'b0000101;
    localparam logic [6:0] OPM_MAC   = 7'b0100101;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_LOG = 4'b1100;
    localparam logic [3:0] ALU_XOR = 4'b0100;

    // ce order is {CEA2, CEB2, CEC, CEM}
    localparam logic [3:0] CE_ALU = 4'b1010;
    localparam logic [3:0] CE_MUL = 4'b1101;

    typedef struct packed {
        logic [6:0] opmode;
        logic [3:0] alumode;
        logic [3:0] ce;
        logic       wb_en;
        logic       illegal;
    } dec_t;

    function automatic dec_t decode_op(input logic [4:0] opc);
        dec_t d;
        d = '0;
        case (opc)
            OP_NOP: d = '0;
            OP_ADD: d = '{OPM_AB_C,  ALU_ADD, CE_ALU, 1'b1, 1'b0};
            OP_SUB: d = '{OPM_AB_C,  ALU_SUB, CE_ALU, 1'b1, 1'b0};
            OP_MUL: d = '{OPM_MUL,   ALU_ADD, CE_MUL, 1'b1, 1'b0};
            OP_MAC: d = '{OPM_MAC,   ALU_ADD, CE_MUL, 1'b1, 1'b0};
            OP_AND: d = '{OPM_AB_C,  ALU_LOG, CE_ALU, 1'b1, 1'b0};
            OP_OR:  d = '{OPM_AB_CO, ALU_LOG, CE_ALU, 1'b1, 1'b0};
            OP_XOR: d = '{OPM_AB_C,  ALU_XOR, CE_ALU, 1'b1, 1'b0};
            default: d = '{OPM_NONE, ALU_ADD, 4'b0000, 1'b0, 1'b1};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_issue_hazard_scoreboard.sv
// In-flight destination tracker: a HAZ_DEPTH-deep {valid, rd} shift register
// plus the RAW compare of the candidate instruction's sources against it.
module hazard_scoreboard #(
    parameter int HAZ_DEPTH = 3,
    parameter int RF_AW     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             push_valid,
    input  logic [RF_AW-1:0] push_rd,
    input  logic             chk_valid,
    input  logic [RF_AW-1:0] chk_rs1,
    input  logic [RF_AW-1:0] chk_rs2,
    output logic             hazard
);

    logic [HAZ_DEPTH-1:0] vld_q, vld_d;
    logic [RF_AW-1:0]     rd_q [HAZ_DEPTH];
    logic [RF_AW-1:0]     rd_d [HAZ_DEPTH];

    // next-state of the in-flight shift register
    always_comb begin
        vld_d = vld_q;
        rd_d  = rd_q;
        if (en) begin
            vld_d[0] = push_valid;
            rd_d[0]  = push_rd;
            for (int i = 1; i < HAZ_DEPTH; i++) begin
                vld_d[i] = vld_q[i-1];
                rd_d[i]  = rd_q[i-1];
            end
        end else begin
            vld_d = vld_q;
        end
    end

    // in-flight shift register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < HAZ_DEPTH; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            rd_q  <= rd_d;
        end
    end

    // RAW compare against every valid in-flight destination
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (chk_valid && vld_q[i] && ((rd_q[i] == chk_rs1) || (rd_q[i] == chk_rs2))) begin
                hazard = 1'b1;
            end else begin
                hazard = hazard;
            end
        end
    end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes one instruction per enabled cycle into DSP48E1
// controls, stalling with bubbles while a RAW hazard against in-flight writes exists.
module decode_issue
    import decode_issue_pkg::*;
#(
    parameter int HAZ_DEPTH = 3,
    parameter int RF_AW     = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [31:0]      INSTR,
    input  logic             INSTR_VALID,
    output logic             INSTR_READY,
    output logic [6:0]       OPMODE,
    output logic [3:0]       ALUMODE,
    output logic             CEA2,
    output logic             CEB2,
    output logic             CEC,
    output logic             CEM,
    output logic [RF_AW-1:0] RS1_ADDR,
    output logic [RF_AW-1:0] RS2_ADDR,
    output logic [RF_AW-1:0] RD_ADDR,
    output logic             WB_EN,
    output logic [15:0]      STALL_CNT
);

    state_e           state_q, state_d;
    logic [31:0]      held_q, held_d;
    logic [6:0]       opmode_q, opmode_d;
    logic [3:0]       alumode_q, alumode_d;
    logic [3:0]       ce_q, ce_d;
    logic [RF_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic             wb_en_q, wb_en_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    logic [31:0]      cur_instr_s;
    logic             cur_valid_s;
    logic [RF_AW-1:0] rs1_s, rs2_s, rd_s;
    dec_t             dec_s;
    logic             hazard_s;
    logic             push_valid_s;
    logic [11:0]      unused_s;

    // A stalled instruction is held internally, so BUBBLE checks and issues the held copy
    always_comb begin
        if (state_q == ST_BUBBLE) begin
            cur_instr_s = held_q;
            cur_valid_s = 1'b1;
        end else begin
            cur_instr_s = INSTR;
            cur_valid_s = INSTR_VALID;
        end
    end

    assign unused_s = cur_instr_s[11:0];
    assign rs1_s    = RF_AW'(cur_instr_s[RS1_MSB:RS1_LSB]);
    assign rs2_s    = RF_AW'(cur_instr_s[RS2_MSB:RS2_LSB]);
    assign rd_s     = RF_AW'(cur_instr_s[RD_MSB:RD_LSB]);
    assign dec_s    = decode_op(cur_instr_s[OPC_MSB:OPC_LSB]);

    hazard_scoreboard #(
        .HAZ_DEPTH (HAZ_DEPTH),
        .RF_AW     (RF_AW)
    ) u_hazard_scoreboard (
        .clk        (CLK),
        .rst_n      (RESET),
        .en         (ENABLE),
        .push_valid (push_valid_s),
        .push_rd    (rd_s),
        .chk_valid  (cur_valid_s && dec_s.wb_en),
        .chk_rs1    (rs1_s),
        .chk_rs2    (rs2_s),
        .hazard     (hazard_s)
    );

    assign INSTR_READY = ENABLE && (state_q == ST_ISSUE) && !hazard_s;

    // issue FSM next state, decoded outputs and stall counter
    always_comb begin
        state_d      = state_q;
        held_d       = held_q;
        opmode_d     = opmode_q;
        alumode_d    = alumode_q;
        ce_d         = ce_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        wb_en_d      = wb_en_q;
        stall_cnt_d  = stall_cnt_q;
        push_valid_s = 1'b0;
        if (ENABLE) begin
            opmode_d  = 7'd0;
            alumode_d = 4'd0;
            ce_d      = 4'd0;
            rs1_d     = '0;
            rs2_d     = '0;
            rd_d      = '0;
            wb_en_d   = 1'b0;
            if (hazard_s) begin
                state_d     = ST_BUBBLE;
                held_d      = cur_instr_s;
                stall_cnt_d = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;
            end else begin
                state_d = ST_ISSUE;
                held_d  = 32'd0;
                if (cur_valid_s) begin
                    opmode_d     = dec_s.opmode;
                    alumode_d    = dec_s.alumode;
                    ce_d         = dec_s.ce;
                    rs1_d        = rs1_s;
                    rs2_d        = rs2_s;
                    rd_d         = rd_s;
                    wb_en_d      = dec_s.wb_en && !dec_s.illegal;
                    push_valid_s = dec_s.wb_en && !dec_s.illegal;
                end else begin
                    push_valid_s = 1'b0;
                end
            end
        end else begin
            push_valid_s = 1'b0;
        end
    end

    // state and output registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_ISSUE;
            held_q      <= 32'd0;
            opmode_q    <= 7'd0;
            alumode_q   <= 4'd0;
            ce_q        <= 4'd0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            wb_en_q     <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            opmode_q    <= opmode_d;
            alumode_q   <= alumode_d;
            ce_q        <= ce_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            wb_en_q     <= wb_en_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign OPMODE    = opmode_q;
    assign ALUMODE   = alumode_q;
    assign CEA2      = ce_q[3];
    assign CEB2      = ce_q[2];
    assign CEC       = ce_q[1];
    assign CEM       = ce_q[0];
    assign RS1_ADDR  = rs1_q;
    assign RS2_ADDR  = rs2_q;
    assign RD_ADDR   = rd_q;
    assign WB_EN     = wb_en_q;
    assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: hand-computed expectations checked with
// immediate assertions after each step.
module tb_decode_issue;
    import decode_issue_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        ENABLE = 1'b0;
    logic [31:0] INSTR = 32'h0;
    logic        INSTR_VALID = 1'b0;
    logic        INSTR_READY;
    logic [6:0]  OPMODE;
    logic [3:0]  ALUMODE;
    logic        CEA2, CEB2, CEC, CEM;
    logic [4:0]  RS1_ADDR, RS2_ADDR, RD_ADDR;
    logic        WB_EN;
    logic [15:0] STALL_CNT;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    decode_issue #(.HAZ_DEPTH(3), .RF_AW(5)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .INSTR(INSTR),
        .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
        .OPMODE(OPMODE), .ALUMODE(ALUMODE),
        .CEA2(CEA2), .CEB2(CEB2), .CEC(CEC), .CEM(CEM),
        .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR), .RD_ADDR(RD_ADDR),
        .WB_EN(WB_EN), .STALL_CNT(STALL_CNT)
    );

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, rs2, 12'h000};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] w);
        INSTR_VALID = v;
        INSTR = w;
        #1;
    endtask

    task automatic flush();
        drive(1'b0, 32'h0);
        repeat (3) tick();
    endtask

    initial begin
        // reset state
        repeat (2) tick();
        chk("rst_opmode", 32'(OPMODE), 32'h0);
        chk("rst_alumode", 32'(ALUMODE), 32'h0);
        chk("rst_stall", 32'(STALL_CNT), 32'h0);
        chk("rst_wb", 32'(WB_EN), 32'h0);
        RESET = 1'b1;
        ENABLE = 1'b1;
        drive(1'b0, 32'h0);
        chk("ready_idle", 32'(INSTR_READY), 32'h1);

        // independent MUL then AND back-to-back
        drive(1'b1, mk(OP_MUL, 5'd5, 5'd6, 5'd7));
        tick();
        chk("mul_opmode", 32'(OPMODE), 32'h05);
        chk("mul_ce", 32'({CEA2, CEB2, CEC, CEM}), 32'hD);
        chk("mul_rd", 32'(RD_ADDR), 32'd5);
        drive(1'b1, mk(OP_AND, 5'd8, 5'd9, 5'd10));
        chk("and_ready", 32'(INSTR_READY), 32'h1);
        tick();
        chk("and_opmode", 32'(OPMODE), 32'h33);
        chk("and_alumode", 32'(ALUMODE), 32'hC);
        chk("and_ce", 32'({CEA2, CEB2, CEC, CEM}), 32'hA);
        chk("and_stall", 32'(STALL_CNT), 32'h0);
        drive(1'b0, 32'h0);
        tick();
        chk("nop_wb", 32'(WB_EN), 32'h0);
        chk("nop_ce", 32'({CEA2, CEB2, CEC, CEM}), 32'h0);
        flush();

        // ADD r3,r1,r2 then dependent SUB r4,r3,r1: three bubbles
        drive(1'b1, mk(OP_ADD, 5'd3, 5'd1, 5'd2));
        tick();
        chk("add_wb", 32'(WB_EN), 32'h1);
        chk("add_rd", 32'(RD_ADDR), 32'd3);
        drive(1'b1, mk(OP_SUB, 5'd4, 5'd3, 5'd1));
        chk("sub_ready_haz", 32'(INSTR_READY), 32'h0);
        tick();
        chk("bub1_wb", 32'(WB_EN), 32'h0);
        chk("bub1_stall", 32'(STALL_CNT), 32'd1);
        drive(1'b0, 32'h0);
        chk("bub_ready", 32'(INSTR_READY), 32'h0);
        tick();
        chk("bub2_stall", 32'(STALL_CNT), 32'd2);
        tick();
        chk("bub3_stall", 32'(STALL_CNT), 32'd3);
        chk("bub3_opmode", 32'(OPMODE), 32'h0);
        tick();
        chk("sub_alumode", 32'(ALUMODE), 32'h3);
        chk("sub_opmode", 32'(OPMODE), 32'h33);
        chk("sub_rd", 32'(RD_ADDR), 32'd4);
        chk("sub_rs1", 32'(RS1_ADDR), 32'd3);
        chk("sub_rs2", 32'(RS2_ADDR), 32'd1);
        chk("sub_stall", 32'(STALL_CNT), 32'd3);
        chk("sub_ready_after", 32'(INSTR_READY), 32'h1);
        flush();

        // ENABLE low for 5 cycles during a bubble
        drive(1'b1, mk(OP_ADD, 5'd3, 5'd1, 5'd2));
        tick();
        drive(1'b1, mk(OP_SUB, 5'd4, 5'd3, 5'd1));
        tick();
        chk("en_bub_stall", 32'(STALL_CNT), 32'd4);
        drive(1'b0, 32'h0);
        ENABLE = 1'b0;
        #1;
        chk("en_low_ready", 32'(INSTR_READY), 32'h0);
        repeat (5) tick();
        chk("en_low_stall", 32'(STALL_CNT), 32'd4);
        chk("en_low_wb", 32'(WB_EN), 32'h0);
        chk("en_low_opmode", 32'(OPMODE), 32'h0);
        ENABLE = 1'b1;
        tick();
        chk("en_resume_stall1", 32'(STALL_CNT), 32'd5);
        tick();
        chk("en_resume_stall2", 32'(STALL_CNT), 32'd6);
        tick();
        chk("en_sub_alumode", 32'(ALUMODE), 32'h3);
        chk("en_sub_stall", 32'(STALL_CNT), 32'd6);
        flush();

        // illegal opcode 31 issues as NOP; its rd must not create a hazard
        drive(1'b1, mk(5'd31, 5'd9, 5'd1, 5'd2));
        tick();
        chk("ill_wb", 32'(WB_EN), 32'h0);
        chk("ill_opmode", 32'(OPMODE), 32'h0);
        chk("ill_ce", 32'({CEA2, CEB2, CEC, CEM}), 32'h0);
        drive(1'b1, mk(OP_XOR, 5'd10, 5'd9, 5'd11));
        chk("xor_ready", 32'(INSTR_READY), 32'h1);
        tick();
        chk("xor_alumode", 32'(ALUMODE), 32'h4);
        chk("xor_wb", 32'(WB_EN), 32'h1);
        chk("xor_rd", 32'(RD_ADDR), 32'd10);
        chk("xor_stall", 32'(STALL_CNT), 32'd6);
        flush();

        // reset asserted mid-stall
        drive(1'b1, mk(OP_ADD, 5'd3, 5'd1, 5'd2));
        tick();
        drive(1'b1, mk(OP_SUB, 5'd4, 5'd3, 5'd1));
        tick();
        chk("rs_pre_stall", 32'(STALL_CNT), 32'd7);
        #2;
        RESET = 1'b0;
        #1;
        chk("rs_async_stall", 32'(STALL_CNT), 32'h0);
        chk("rs_async_opmode", 32'(OPMODE), 32'h0);
        chk("rs_async_alumode", 32'(ALUMODE), 32'h0);
        tick();
        RESET = 1'b1;
        drive(1'b0, 32'h0);
        chk("rs_ready", 32'(INSTR_READY), 32'h1);
        drive(1'b1, mk(OP_OR, 5'd12, 5'd3, 5'd1));
        chk("rs_or_ready", 32'(INSTR_READY), 32'h1);
        tick();
        chk("rs_or_opmode", 32'(OPMODE), 32'h3B);
        chk("rs_or_alumode", 32'(ALUMODE), 32'hC);
        chk("rs_or_stall", 32'(STALL_CNT), 32'h0);
        drive(1'b0, 32'h0);
        tick();
        chk("rs_no_held_wb", 32'(WB_EN), 32'h0);
        flush();

        // stall counter saturation
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        #1;
        chk("sat_preload", 32'(STALL_CNT), 32'hFFFE);
        drive(1'b1, mk(OP_ADD, 5'd3, 5'd1, 5'd2));
        tick();
        drive(1'b1, mk(OP_SUB, 5'd4, 5'd3, 5'd1));
        tick();
        chk("sat_bub1", 32'(STALL_CNT), 32'hFFFF);
        drive(1'b0, 32'h0);
        tick();
        chk("sat_bub2", 32'(STALL_CNT), 32'hFFFF);
        tick();
        chk("sat_bub3", 32'(STALL_CNT), 32'hFFFF);
        tick();
        chk("sat_sub_alumode", 32'(ALUMODE), 32'h3);
        chk("sat_final", 32'(STALL_CNT), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL have parameter HAZ_DEPTH, default 3, meaning the number of issue slots between decode and register-file writeback that are checked for RAW hazards.
REQ-002 SHALL have parameter RF_AW, default 5, meaning the register-file address width.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port RESET, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ENABLE, input, 1, global pipeline advance; low = pause.
REQ-006 SHALL have port INSTR, input, 32, instruction word: [31:27] opcode, [26:22] rd, [21:17] rs1, [16:12] rs2, [11:0] unused.
REQ-007 SHALL have port INSTR_VALID, input, 1, which qualifies INSTR.
REQ-008 SHALL have port INSTR_READY, output, 1; an instruction is consumed when INSTR_VALID and INSTR_READY and ENABLE are all high.
REQ-009 SHALL have ports OPMODE (output, 7) and ALUMODE (output, 4), the DSP48E1 modes for the EXE2 stage.
REQ-010 SHALL have ports CEA2, CEB2, CEC and CEM, each output, 1, the DSP48E1 clock enables for the EXE2 stage.
REQ-011 SHALL have ports RS1_ADDR, RS2_ADDR and RD_ADDR, each output, RF_AW, register addresses forwarded down the pipe.
REQ-012 SHALL have port WB_EN, output, 1, marking that the issued instruction writes rd.
REQ-013 SHALL have port STALL_CNT, output, 16, a saturating count of hazard bubbles.

Function
REQ-014 SHALL register all outputs except INSTR_READY; decode-to-output latency SHALL be exactly 1 enabled cycle.
REQ-015 SHALL decode the opcodes as follows (OPMODE/ALUMODE/CEA2 CEB2 CEC CEM/WB_EN):
- NOP=0: 0000000/0000/0000/0
- ADD=1: 0110011/0000/1010/1
- SUB=2: 0110011/0011/1010/1
- MUL=3: 0000101/0000/1101/1
- MAC=4: 0100101/0000/1101/1
- AND=5: 0110011/1100/1010/1
- OR=6: 0111011/1100/1010/1
- XOR=7: 0110011/0100/1010/1
REQ-016 SHALL decode opcodes 8-31 as NOP and SHALL pulse an internal illegal flag that is not exported.
REQ-017 SHALL keep an in-flight shift register of HAZ_DEPTH entries, each {valid, rd}, that advances once per enabled cycle; an issued bubble or NOP SHALL shift in valid=0.
REQ-018 SHALL declare a hazard when INSTR_VALID is high and rs1 or rs2 equals rd of any valid in-flight entry; opcode NOP SHALL never hazard.
REQ-019 SHALL run a two-state FSM: ISSUE (INSTR_READY=1) and BUBBLE (INSTR_READY=0, outputs decode as NOP).
REQ-020 SHALL move ISSUE→BUBBLE on a hazard, stay in BUBBLE while the hazard persists, and move BUBBLE→ISSUE on the first enabled cycle the hazard clears, issuing the held instruction in that cycle.
REQ-021 SHALL drive INSTR_READY combinationally: high only in ISSUE with no hazard.
REQ-022 SHALL increment STALL_CNT by one per enabled bubble cycle and saturate at 16'hFFFF.
REQ-023 SHALL, while ENABLE is low, hold every register, the FSM state, the shift register and STALL_CNT, and drive INSTR_READY low.
REQ-024 SHALL issue a NOP (all CE=0, WB_EN=0) when INSTR_VALID is low in ISSUE.
REQ-025 SHALL apply the hazard check even when HAZ_DEPTH=1; back-to-back dependent instructions SHALL incur exactly HAZ_DEPTH bubbles.

Reset
REQ-026 SHALL, while RESET is low, asynchronously force the state to ISSUE, clear all outputs and STALL_CNT to 0, and invalidate all in-flight entries.
REQ-027 SHALL discard any held instruction on a reset asserted mid-stall; the first enabled cycle after release SHALL accept a new instruction.

Structure
REQ-028 SHALL take the opcode encodings, the OPMODE/ALUMODE constants and the instruction field positions from the shared parameters include used by the EXE stages.
REQ-029 SHALL contain one sub-module, hazard_scoreboard, holding the in-flight shift register and the compare logic, with a 1-bit hazard output.

Verification
REQ-030 SHALL verify that reset low mid-stream produces OPMODE=0, ALUMODE=0, STALL_CNT=0 and INSTR_READY=1 after release.
REQ-031 SHALL verify that ADD r3,r1,r2 followed one cycle later by SUB r4,r3,r1 gives 3 bubbles, then SUB issues with ALUMODE=0011 and STALL_CNT=3.
REQ-032 SHALL verify that ENABLE low for 5 cycles during BUBBLE leaves the outputs frozen and STALL_CNT unchanged, and that bubbling resumes afterwards.
REQ-033 SHALL verify that independent MUL r5,r6,r7 then AND r8,r9,r10 issue back-to-back with CEM=1 then CEM=0, and that STALL_CNT stays 0.
REQ-034 SHALL verify that opcode 31 issues as a NOP with WB_EN=0 and that the following independent instruction issues normally.
REQ-035 SHALL verify that forcing STALL_CNT near 16'hFFFF and then creating a hazard holds STALL_CNT at 16'hFFFF.
